// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared definitions for pipe_stage_reg.
//   state_t      : occupancy-coded stage state (EMPTY/BUSY/FULL), the
//                  encoding doubles as the held-beat count.
//   DEF_DATA_W   : default payload width.
//   DEF_CTRL_W   : default control width (RegWrite, MemRead, MemWrite,
//                  MemToReg, Branch).
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake/payload bundle of one pipeline stage.
//   flush                     : synchronous kill of held beats
//   in_valid/in_ready         : upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready       : downstream handshake, out_data/out_ctrl payload
//   occupancy                 : number of beats held (0..2)
// Modports: slave = the stage itself, master = surrounding pipeline.
interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_pkg::DEF_DATA_W,
  parameter int CTRL_W = pipe_pkg::DEF_CTRL_W
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register replacing the
// hand-written EX/MEM-style stage registers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : pipe_stage_reg_if.slave (flush, in_*, out_*, occupancy)
// Build option PIPE_STAGE_SKID_EN: when defined, a second (skid) entry lets
// in_ready come straight from a flop; when undefined, a single entry with
// in_ready = !out_valid | out_ready.
// out_ctrl is masked to zero on bubbles so downstream never sees stale
// write/branch enables; out_data is left unmasked.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              in_ready;
  logic              out_valid;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_fire) state_nxt = BUSY;
`ifdef PIPE_STAGE_SKID_EN
      BUSY: begin
        if (in_fire && !out_fire)      state_nxt = FULL;
        else if (!in_fire && out_fire) state_nxt = EMPTY;
      end
      // in_ready is low in FULL, so only the drain can happen here
      FULL: if (out_fire) state_nxt = BUSY;
`else
      BUSY: if (out_fire && !in_fire) state_nxt = EMPTY;
`endif
      default: state_nxt = EMPTY;
    endcase
    if (bus.flush) state_nxt = EMPTY;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_ready_q;

  // Registered ready: looks one state ahead so no out_ready->in_ready path.
  assign in_ready = in_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (!bus.flush) begin
        if (state == FULL && out_fire) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end else if (in_fire && (state == EMPTY || out_fire)) begin
          main_data <= bus.in_data;
          main_ctrl <= bus.in_ctrl;
        end else if (in_fire) begin
          // BUSY and main is stalled: park the new beat behind it
          skid_data <= bus.in_data;
          skid_ctrl <= bus.in_ctrl;
        end
      end
    end
  end
`else
  assign in_ready = !out_valid | bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (!bus.flush && in_fire) begin
        main_data <= bus.in_data;
        main_ctrl <= bus.in_ctrl;
      end
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = out_valid ? main_ctrl : '0;
  assign bus.occupancy = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; covers both build variants via
// PIPE_STAGE_SKID_EN. Inputs change 1 ns after the rising edge and outputs
// are sampled there too, well clear of the next edge.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(5)) bus ();

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held with a beat offered: nothing may be captured
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h55;
    bus.in_ctrl   = 5'h1F;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_ctrl",  32'(bus.out_ctrl),  32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // release; first edge accepts, visible one cycle after in_fire
    reset = 1'b1;
    tick();
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_data",  bus.out_data,       32'h55);
    chk("first_ctrl",  32'(bus.out_ctrl),  32'h1F);
    chk("first_occ",   32'(bus.occupancy), 32'd1);
    bus.in_valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    chk("busy_in_ready_skid", 32'(bus.in_ready), 32'd1);
`else
    #1;
    chk("busy_in_ready_stall", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("busy_in_ready_comb", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h66;
    bus.in_ctrl  = 5'h1F;
    tick();
    chk("replace_data",  bus.out_data,       32'h66);
    chk("replace_valid", 32'(bus.out_valid), 32'd1);
    chk("replace_occ",   32'(bus.occupancy), 32'd1);
    bus.in_valid = 1'b0;
`endif

    // drain with no new input: ctrl must read as bubble
    bus.out_ready = 1'b1;
    tick();
    chk("bubble_valid", 32'(bus.out_valid), 32'd0);
    chk("bubble_ctrl",  32'(bus.out_ctrl),  32'd0);
    chk("bubble_occ",   32'(bus.occupancy), 32'd0);

    // back-to-back streaming
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 5'h01;
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 32'h11 * i;
      tick();
      chk("stream_data",     bus.out_data,       32'h11 * i);
      chk("stream_occ",      32'(bus.occupancy), 32'd1);
      chk("stream_in_ready", 32'(bus.in_ready),  32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 32'(bus.out_valid), 32'd0);

    // flush while BUSY with a same-cycle in_fire
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hD0;
    bus.in_ctrl   = 5'h02;
    tick();
    chk("pre_flush_data", bus.out_data, 32'hD0);
    bus.flush     = 1'b1;
    bus.in_data   = 32'hC0;
    bus.out_ready = 1'b1;
    tick();
    chk("flush_occ",      32'(bus.occupancy), 32'd0);
    chk("flush_valid",    32'(bus.out_valid), 32'd0);
    chk("flush_ctrl",     32'(bus.out_ctrl),  32'd0);
    chk("flush_in_ready", 32'(bus.in_ready),  32'd1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("flush_no_c0", 32'(bus.out_valid), 32'd0);

`ifdef PIPE_STAGE_SKID_EN
    // backpressure fills main then skid
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA0;
    tick();
    chk("bp_one_in_ready", 32'(bus.in_ready),  32'd1);
    chk("bp_one_occ",      32'(bus.occupancy), 32'd1);
    bus.in_data = 32'hB0;
    tick();
    bus.in_valid = 1'b0;
    chk("bp_full_occ",      32'(bus.occupancy), 32'd2);
    chk("bp_full_in_ready", 32'(bus.in_ready),  32'd0);
    chk("bp_full_data",     bus.out_data,       32'hA0);
    tick();
    chk("bp_stable_data", bus.out_data, 32'hA0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_drain0_data", bus.out_data, 32'hA0);
    tick();
    chk("bp_drain1_data",     bus.out_data,       32'hB0);
    chk("bp_drain1_occ",      32'(bus.occupancy), 32'd1);
    chk("bp_drain1_in_ready", 32'(bus.in_ready),  32'd1);
    tick();
    chk("bp_empty_occ", 32'(bus.occupancy), 32'd0);

    // flush while FULL
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA0;
    tick();
    bus.in_data = 32'hB0;
    tick();
    chk("ff_full_occ", 32'(bus.occupancy), 32'd2);
    bus.flush   = 1'b1;
    bus.in_data = 32'hC0;
    tick();
    chk("ff_occ",      32'(bus.occupancy), 32'd0);
    chk("ff_valid",    32'(bus.out_valid), 32'd0);
    chk("ff_ctrl",     32'(bus.out_ctrl),  32'd0);
    chk("ff_in_ready", 32'(bus.in_ready),  32'd1);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("ff_no_c0", 32'(bus.out_valid), 32'd0);
`endif

    // reset mid-transfer discards the held beat; accept right after release
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h44;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_held_occ", 32'(bus.occupancy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_occ",   32'(bus.occupancy), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    tick();
    chk("mid_rel_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_rel_data",  bus.out_data,       32'h77);
    bus.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (alu result, store data, branch target, etc. concatenated).
REQ-002 SHALL have parameter CTRL_W, default 5: width of the control field (RegWrite, MemRead, MemWrite, MemToReg, Branch in the default build).
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1: synchronous kill of all held beats.
REQ-006 SHALL have port in_valid, input, 1: upstream beat present.
REQ-007 SHALL have port in_ready, output, 1: stage can accept a beat.
REQ-008 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W: upstream control bits.
REQ-010 SHALL have port out_valid, output, 1: downstream beat present.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts.
REQ-012 SHALL have port out_data, output, DATA_W: oldest held payload.
REQ-013 SHALL have port out_ctrl, output, CTRL_W: oldest held control, forced all-zero whenever out_valid=0 (bubble).
REQ-014 SHALL have port occupancy, output, 2: number of held beats (0..2).

Function
REQ-015 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; data moves only on fire.
REQ-016 SHALL hold beats in a main register (always the oldest) and a skid register, with strict FIFO order.
REQ-017 SHALL implement states EMPTY (0 held), BUSY (main only) and FULL (main+skid).
REQ-018 EMPTY: in_fire -> BUSY, main <= in.
REQ-019 BUSY: in_fire & !out_fire -> FULL, skid <= in; !in_fire & out_fire -> EMPTY; in_fire & out_fire -> BUSY, main <= in.
REQ-020 FULL: out_fire -> BUSY, main <= skid; in_fire cannot occur.
REQ-021 SHALL drive in_ready from a register, equal to (next state != FULL); no combinational path from out_ready to in_ready.
REQ-022 SHALL give 1-cycle latency from in_fire to out_valid and sustain 1 beat/cycle with out_ready held high.
REQ-023 SHALL hold out_data/out_ctrl stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 SHALL force EMPTY on the next edge, dropping main, skid and any same-cycle in_fire (flush wins over every other event).
REQ-025 SHALL not modify payload bits; the skid register is not cleared on drain.

Reset
REQ-026 While reset=0: state EMPTY, out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1, skid register 0.
REQ-027 Reset asserted mid-transfer SHALL discard all held beats; first accept is possible on the first rising edge after release.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined: two-entry skid behaviour per REQ-016..REQ-021.
REQ-029 Macro PIPE_STAGE_SKID_EN undefined: no skid register, states EMPTY/BUSY only, in_ready = !out_valid | out_ready (combinational), occupancy max 1; all other requirements unchanged.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and the default DATA_W/CTRL_W constants.
REQ-031 SHALL be a single module with no sub-modules; it replaces per-stage hand-written pipeline registers (EX/MEM and siblings) by instantiation.

Verification
REQ-032 Reset: hold reset=0 with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; after release, first in_fire is visible at out_valid one cycle later.
REQ-033 Streaming: out_ready=1, send 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles, occupancy stays 1, in_ready stays 1.
REQ-034 Backpressure (SKID_EN): out_ready=0, send 0xA0,0xB0 -> occupancy=2, in_ready=0 next cycle, out_data=0xA0 stable; raise out_ready -> 0xA0 then 0xB0, in_ready back to 1.
REQ-035 Flush: FULL with 0xA0/0xB0, assert flush with in_valid=1 in_data=0xC0 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, 0xC0 never appears at the output.
REQ-036 Bubble masking: in_ctrl=5'b11111 accepted then drained with no new input -> out_ctrl=5'b00000 on the cycle out_valid falls.
REQ-037 Without SKID_EN: out_ready=0 with main held -> in_ready=0 combinationally; out_ready=1 and in_valid=1 in the same cycle -> replacement beat accepted, occupancy stays 1.
